// File: rtl/ddr3_responder.sv
// Cycle-level DDR3 device stand-in: command decode, init sequencing, open-row tracking,
// a small 16-bit backing array, fixed-latency 2-beat bursts and sticky protocol-error reporting.
module ddr3_responder #(
  parameter int ROWW = 4,
  parameter int COLW = 6,
  parameter int RL   = 7,
  parameter int WL   = 7,
  parameter int NMRS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ddrreset,
  input  logic        ddrcke,
  input  logic        ddrcs,
  input  logic        ddrras,
  input  logic        ddrcas,
  input  logic        ddrwe,
  input  logic [14:0] ddra,
  input  logic [2:0]  ddrba,
  input  logic [15:0] ddrdqout,
  input  logic        ddrdqt,
  output logic [15:0] ddrdqin,
  output logic        ready,
  output logic [59:0] mr,
  output logic        err,
  output logic [2:0]  errcode
);

  localparam int AW    = ROWW + COLW;
  localparam int DEPTH = 1 << AW;
  localparam int LMAX  = (RL > WL) ? RL : WL;
  localparam int CNTW  = $clog2(LMAX + 2);
  localparam int MCW   = (NMRS > 1) ? $clog2(NMRS + 1) : 1;

  typedef enum logic [2:0] {
    S_RST, S_WCKE, S_MRS, S_WZQ, S_RDY
  } state_t;

  typedef enum logic [2:0] {
    C_MRS = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011,
    C_WR  = 3'b100, C_RD  = 3'b101, C_ZQC = 3'b110, C_NOP = 3'b111
  } cmd_t;

  state_t            state_q;
  logic [MCW-1:0]    mrs_cnt_q;
  logic              row_open_q;
  logic [ROWW-1:0]   row_q;
  logic [CNTW-1:0]   cnt_q;
  logic              bwr_q;
  logic [ROWW-1:0]   brow_q;
  logic [COLW-1:0]   bcol_q;
  logic [15:0]       dq_q;
  logic              ready_q;
  logic [59:0]       mr_q;
  logic              err_q;
  logic [2:0]        errcode_q;

  logic [15:0]       mem [DEPTH];

  cmd_t              cmd;
  logic              beat0, beat1, busy, wbeat, mem_we, accept;
  logic [AW-1:0]     beat_addr;
  logic [2:0]        cmd_code, viol_code;

  // cnt_q counts edges down to the burst's last beat: 2 marks beat 0, 1 marks beat 1.
  always_comb begin
    cmd = C_NOP;
    if (!ddrcs && ddrcke) cmd = cmd_t'({ddrras, ddrcas, ddrwe});
    beat0     = (cnt_q == CNTW'(2));
    beat1     = (cnt_q == CNTW'(1));
    busy      = (cnt_q > CNTW'(1));
    beat_addr = {brow_q, beat1 ? (bcol_q + COLW'(1)) : bcol_q};
    wbeat     = ddrreset && bwr_q && (beat0 || beat1);
    mem_we    = wbeat && !ddrdqt;
    cmd_code  = '0;
    accept    = 1'b0;
    if (state_q != S_RDY) begin
      if (cmd != C_NOP && cmd != C_MRS && !(state_q == S_WZQ && cmd == C_ZQC))
        cmd_code = 3'd1;
    end else begin
      case (cmd)
        C_ACT, C_REF: if (row_open_q) cmd_code = 3'd2;
        C_RD, C_WR: begin
          if (!row_open_q)  cmd_code = 3'd3;
          else if (busy)    cmd_code = 3'd5;
          else              accept   = 1'b1;
        end
        default: ;
      endcase
    end
    viol_code = (wbeat && ddrdqt) ? 3'd4 : cmd_code;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[beat_addr] <= ddrdqout;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_RST;
      mrs_cnt_q  <= '0;
      row_open_q <= 1'b0;
      row_q      <= '0;
      cnt_q      <= '0;
      bwr_q      <= 1'b0;
      brow_q     <= '0;
      bcol_q     <= '0;
      dq_q       <= '0;
      ready_q    <= 1'b0;
      mr_q       <= '0;
      err_q      <= 1'b0;
      errcode_q  <= '0;
    end else if (!ddrreset) begin
      state_q    <= S_RST;
      mrs_cnt_q  <= '0;
      row_open_q <= 1'b0;
      cnt_q      <= '0;
      dq_q       <= '0;
      ready_q    <= 1'b0;
    end else begin
      dq_q <= (!bwr_q && (beat0 || beat1)) ? mem[beat_addr] : '0;

      if (accept) begin
        cnt_q  <= (cmd == C_RD) ? CNTW'(RL + 1) : CNTW'(WL + 1);
        bwr_q  <= (cmd == C_WR);
        brow_q <= row_q;
        bcol_q <= ddra[COLW-1:0];
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - CNTW'(1);
      end

      if (!err_q && viol_code != '0) begin
        err_q     <= 1'b1;
        errcode_q <= viol_code;
      end

      case (state_q)
        S_RST:  state_q <= S_WCKE;
        S_WCKE: if (ddrcke) state_q <= S_MRS;
        S_MRS: begin
          if (cmd == C_MRS) begin
            if (!ddrba[2]) begin
              case (ddrba[1:0])
                2'd0: mr_q[14:0]  <= ddra;
                2'd1: mr_q[29:15] <= ddra;
                2'd2: mr_q[44:30] <= ddra;
                default: mr_q[59:45] <= ddra;
              endcase
            end
            if (mrs_cnt_q == MCW'(NMRS - 1)) state_q <= S_WZQ;
            else                             mrs_cnt_q <= mrs_cnt_q + MCW'(1);
          end
        end
        S_WZQ: begin
          if (cmd == C_ZQC) begin
            state_q <= S_RDY;
            ready_q <= 1'b1;
          end
        end
        S_RDY: begin
          case (cmd)
            C_ACT: begin
              if (!row_open_q) begin
                row_open_q <= 1'b1;
                row_q      <= ddra[ROWW-1:0];
              end
            end
            C_PRE: row_open_q <= 1'b0;
            C_RD, C_WR: if (accept && ddra[10]) row_open_q <= 1'b0;
            default: ;
          endcase
        end
        default: state_q <= S_RST;
      endcase
    end
  end

  assign ddrdqin = dq_q;
  assign ready   = ready_q;
  assign mr      = mr_q;
  assign err     = err_q;
  assign errcode = errcode_q;

endmodule

// File: tb/tb_ddr3_responder.sv
// Bench for ddr3_responder: directed scenarios plus randomized command streams
// checked against an edge-indexed behavioural model of the device.
module tb_ddr3_responder;
  localparam int ROWW = 4;
  localparam int COLW = 6;
  localparam int RL   = 7;
  localparam int WL   = 7;
  localparam int NMRS = 4;
  localparam int NCOL = 1 << COLW;

  localparam logic [2:0] MRS = 3'd0, REF = 3'd1, PRE = 3'd2, ACT = 3'd3,
                         WR  = 3'd4, RD  = 3'd5, ZQC = 3'd6, NOP = 3'd7;

  logic        clk = 1'b0;
  logic        reset, ddrreset, ddrcke, ddrcs, ddrras, ddrcas, ddrwe;
  logic [14:0] ddra;
  logic [2:0]  ddrba;
  logic [15:0] ddrdqout;
  logic        ddrdqt;
  logic [15:0] ddrdqin;
  logic        ready;
  logic [59:0] mr;
  logic        err;
  logic [2:0]  errcode;

  int checks = 0;
  int errors = 0;

  ddr3_responder #(.ROWW(ROWW), .COLW(COLW), .RL(RL), .WL(WL), .NMRS(NMRS)) dut (
    .clk(clk), .reset(reset), .ddrreset(ddrreset), .ddrcke(ddrcke), .ddrcs(ddrcs),
    .ddrras(ddrras), .ddrcas(ddrcas), .ddrwe(ddrwe), .ddra(ddra), .ddrba(ddrba),
    .ddrdqout(ddrdqout), .ddrdqt(ddrdqt), .ddrdqin(ddrdqin), .ready(ready),
    .mr(mr), .err(err), .errcode(errcode)
  );

  always #5 clk = ~clk;

  // Reference model: init stage 0..4 = RST,WCKE,MRS,WZQ,RDY; bursts tracked by start edge.
  int          m_st, m_mrsn, m_code, m_row, m_bkind, m_bstart, m_brow, m_bcol, m_edge;
  bit          m_ready, m_err, m_open, m_dq_known;
  logic [14:0] m_mr [4];
  logic [15:0] m_mem [1 << (ROWW + COLW)];
  bit          m_known [1 << (ROWW + COLW)];
  logic [15:0] m_dq;

  function automatic void m_flag(input int c);
    if (!m_err) begin
      m_err  = 1'b1;
      m_code = c;
    end
  endfunction

  function automatic void model_reset();
    m_st = 0; m_mrsn = 0; m_ready = 1'b0; m_err = 1'b0; m_code = 0;
    m_open = 1'b0; m_bkind = 0; m_dq = '0; m_dq_known = 1'b1;
    for (int i = 0; i < 4; i++) m_mr[i] = '0;
  endfunction

  function automatic void model_edge();
    int k, lat, addr, old;
    logic [2:0] c;
    m_edge++;
    if (!ddrreset) begin
      m_st = 0; m_mrsn = 0; m_ready = 1'b0; m_open = 1'b0; m_bkind = 0;
      m_dq = '0; m_dq_known = 1'b1;
      return;
    end
    m_dq = '0; m_dq_known = 1'b1;
    if (m_bkind != 0) begin
      lat = (m_bkind == 1) ? RL : WL;
      k   = m_edge - m_bstart;
      if (k == lat || k == lat + 1) begin
        addr = m_brow * NCOL + (m_bcol + k - lat) % NCOL;
        if (m_bkind == 1) begin
          m_dq = m_mem[addr]; m_dq_known = m_known[addr];
        end else if (!ddrdqt) begin
          m_mem[addr] = ddrdqout; m_known[addr] = 1'b1;
        end else m_flag(4);
      end
      if (k >= lat + 1) m_bkind = 0;
    end
    c   = (!ddrcs && ddrcke) ? {ddrras, ddrcas, ddrwe} : NOP;
    old = m_st;
    if (old < 4) begin
      if (c != NOP && c != MRS && !(old == 3 && c == ZQC)) m_flag(1);
      case (old)
        0: m_st = 1;
        1: if (ddrcke) m_st = 2;
        2: if (c == MRS) begin
             if (!ddrba[2]) m_mr[ddrba[1:0]] = ddra;
             m_mrsn++;
             if (m_mrsn == NMRS) m_st = 3;
           end
        default: if (c == ZQC) begin m_st = 4; m_ready = 1'b1; end
      endcase
    end else begin
      case (c)
        ACT: if (m_open) m_flag(2); else begin m_open = 1'b1; m_row = int'(ddra[ROWW-1:0]); end
        REF: if (m_open) m_flag(2);
        PRE: m_open = 1'b0;
        RD, WR: begin
          if (!m_open) m_flag(3);
          else if (m_bkind != 0) m_flag(5);
          else begin
            m_bkind = (c == RD) ? 1 : 2; m_bstart = m_edge;
            m_brow = m_row; m_bcol = int'(ddra[COLW-1:0]);
            if (ddra[10]) m_open = 1'b0;
          end
        end
        default: ;
      endcase
    end
  endfunction

  task automatic step(input logic [2:0] c, input logic [14:0] a, input logic [2:0] b,
                      input logic [15:0] d, input logic t);
    ddrcs = (c == NOP); {ddrras, ddrcas, ddrwe} = c;
    ddra = a; ddrba = b; ddrdqout = d; ddrdqt = t;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cmd(input logic [2:0] c, input logic [14:0] a);
    step(c, a, 3'd0, 16'h0, 1'b1);
  endtask

  task automatic nop();
    step(NOP, 15'd0, 3'd0, 16'h0, 1'b1);
  endtask

  task automatic beat(input logic [15:0] d);
    step(NOP, 15'd0, 3'd0, d, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1; ddrreset = 1'b0; ddrcke = 1'b0; ddrcs = 1'b1;
    {ddrras, ddrcas, ddrwe} = NOP; ddra = '0; ddrba = '0; ddrdqout = '0; ddrdqt = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset = 1'b0;
  endtask

  task automatic do_init_mrs();
    ddrreset = 1'b0; ddrcke = 1'b0; nop();
    ddrreset = 1'b1; nop();
    ddrcke = 1'b1; nop();
    step(MRS, 15'h008, 3'd2, 16'h0, 1'b1);
    step(MRS, 15'h000, 3'd2, 16'h0, 1'b1);
    step(MRS, 15'h422, 3'd0, 16'h0, 1'b1);
    step(MRS, 15'h805, 3'd1, 16'h0, 1'b1);
  endtask

  task automatic do_init();
    do_init_mrs();
    cmd(ZQC, 15'd0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ddrdqin !== 16'h0) begin errors++; $display("FAIL rst_dq: got %h exp 0000", ddrdqin); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b exp 0", ready); end
    checks++; if (mr !== 60'h0) begin errors++; $display("FAIL rst_mr: got %h exp 0", mr); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b exp 0", err); end
    checks++; if (errcode !== 3'd0) begin errors++; $display("FAIL rst_code: got %0d exp 0", errcode); end
  endtask

  task automatic test_init();
    do_init_mrs();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL init_ready_pre: got %b exp 0", ready); end
    cmd(ZQC, 15'd0);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL init_ready: got %b exp 1", ready); end
    checks++; if (mr[29:15] !== 15'h805) begin errors++; $display("FAIL init_mr1: got %h exp 805", mr[29:15]); end
    checks++; if (mr[14:0] !== 15'h422) begin errors++; $display("FAIL init_mr0: got %h exp 422", mr[14:0]); end
    checks++; if (mr[59:30] !== 30'h0) begin errors++; $display("FAIL init_mr32: got %h exp 0", mr[59:30]); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL init_err: got %b exp 0", err); end
  endtask

  task automatic test_write_read();
    cmd(ACT, 15'd3);
    cmd(WR, 15'h405);
    repeat (6) nop();
    beat(16'h1234);
    beat(16'hABCD);
    cmd(ACT, 15'd3);
    cmd(RD, 15'd5);
    repeat (6) nop();
    checks++; if (ddrdqin !== 16'h0) begin errors++; $display("FAIL wr_rd_early: got %h exp 0000", ddrdqin); end
    nop();
    checks++; if (ddrdqin !== 16'h1234) begin errors++; $display("FAIL wr_rd_beat0: got %h exp 1234", ddrdqin); end
    nop();
    checks++; if (ddrdqin !== 16'hABCD) begin errors++; $display("FAIL wr_rd_beat1: got %h exp abcd", ddrdqin); end
    nop();
    checks++; if (ddrdqin !== 16'h0) begin errors++; $display("FAIL wr_rd_after: got %h exp 0000", ddrdqin); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wr_rd_err: got %b exp 0", err); end
  endtask

  task automatic test_wrap();
    cmd(PRE, 15'd0);
    cmd(ACT, 15'd5);
    cmd(WR, 15'd63);
    repeat (6) nop();
    beat(16'h1111);
    beat(16'h2222);
    cmd(RD, 15'h43F);
    repeat (7) nop();
    checks++; if (ddrdqin !== 16'h1111) begin errors++; $display("FAIL wrap_col63: got %h exp 1111", ddrdqin); end
    nop();
    checks++; if (ddrdqin !== 16'h2222) begin errors++; $display("FAIL wrap_col0: got %h exp 2222", ddrdqin); end
    cmd(ACT, 15'd5);
    cmd(RD, 15'h400);
    repeat (7) nop();
    checks++; if (ddrdqin !== 16'h2222) begin errors++; $display("FAIL wrap_rd_col0: got %h exp 2222", ddrdqin); end
    repeat (2) nop();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wrap_err: got %b exp 0", err); end
  endtask

  task automatic test_violations();
    do_reset(); do_init();
    cmd(RD, 15'd5);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL viol_rd_err: got %b exp 1", err); end
    checks++; if (errcode !== 3'd3) begin errors++; $display("FAIL viol_rd_code: got %0d exp 3", errcode); end
    cmd(ACT, 15'd3);
    cmd(ACT, 15'd3);
    checks++; if (errcode !== 3'd3) begin errors++; $display("FAIL viol_first_wins: got %0d exp 3", errcode); end
    do_reset();
    ddrreset = 1'b1; ddrcke = 1'b1;
    nop();
    cmd(ACT, 15'd0);
    checks++; if (err !== 1'b1 || errcode !== 3'd1) begin
      errors++; $display("FAIL viol_preinit: got err=%b code=%0d exp err=1 code=1", err, errcode);
    end
  endtask

  task automatic test_overlap();
    do_reset(); do_init();
    cmd(ACT, 15'd3);
    cmd(RD, 15'd5);
    nop(); nop();
    cmd(RD, 15'd7);
    checks++; if (errcode !== 3'd5) begin errors++; $display("FAIL ovl_code: got %0d exp 5", errcode); end
    repeat (4) nop();
    checks++; if (ddrdqin !== 16'h1234) begin errors++; $display("FAIL ovl_beat0: got %h exp 1234", ddrdqin); end
    nop();
    checks++; if (ddrdqin !== 16'hABCD) begin errors++; $display("FAIL ovl_beat1: got %h exp abcd", ddrdqin); end
    for (int i = 0; i < 6; i++) begin
      nop();
      checks++; if (ddrdqin !== 16'h0) begin errors++; $display("FAIL ovl_no_second[%0d]: got %h exp 0000", i, ddrdqin); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(); do_init();
    cmd(ACT, 15'd3);
    cmd(RD, 15'd5);
    repeat (7) nop();
    checks++; if (ddrdqin !== 16'h1234) begin errors++; $display("FAIL rmid_beat0: got %h exp 1234", ddrdqin); end
    ddrreset = 1'b0;
    nop();
    checks++; if (ddrdqin !== 16'h0) begin errors++; $display("FAIL rmid_dq: got %h exp 0000", ddrdqin); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rmid_ready: got %b exp 0", ready); end
    do_init();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rmid_reinit: got %b exp 1", ready); end
    cmd(ACT, 15'd3);
    cmd(RD, 15'h405);
    repeat (7) nop();
    checks++; if (ddrdqin !== 16'h1234) begin errors++; $display("FAIL rmid_rd: got %h exp 1234", ddrdqin); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rmid_err: got %b exp 0", err); end
  endtask

  task automatic test_back_to_back();
    do_reset(); do_init();
    cmd(ACT, 15'd3);
    cmd(RD, 15'd5);
    repeat (7) nop();
    checks++; if (ddrdqin !== 16'h1234) begin errors++; $display("FAIL b2b_a0: got %h exp 1234", ddrdqin); end
    cmd(RD, 15'h405);
    checks++; if (ddrdqin !== 16'hABCD || err !== 1'b0) begin
      errors++; $display("FAIL b2b_edge: got dq=%h err=%b exp dq=abcd err=0", ddrdqin, err);
    end
    repeat (7) nop();
    checks++; if (ddrdqin !== 16'h1234) begin errors++; $display("FAIL b2b_b0: got %h exp 1234", ddrdqin); end
    nop();
    checks++; if (ddrdqin !== 16'hABCD) begin errors++; $display("FAIL b2b_b1: got %h exp abcd", ddrdqin); end
    cmd(ACT, 15'd3);
    cmd(WR, 15'd5);
    repeat (6) nop();
    beat(16'h5555);
    step(RD, 15'h405, 3'd0, 16'h6666, 1'b0);
    repeat (7) nop();
    checks++; if (ddrdqin !== 16'h5555) begin errors++; $display("FAIL wtr_b0: got %h exp 5555", ddrdqin); end
    nop();
    checks++; if (ddrdqin !== 16'h6666) begin errors++; $display("FAIL wtr_b1: got %h exp 6666", ddrdqin); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wtr_err: got %b exp 0", err); end
  endtask

  task automatic test_random();
    logic [2:0]  c;
    logic [14:0] a;
    int          r;
    for (int round = 0; round < 4; round++) begin
      do_reset(); do_init();
      for (int i = 0; i < 200; i++) begin
        r = $urandom_range(0, 15);
        c = (r < 3) ? ACT : (r == 3) ? PRE : (r < 7) ? RD : (r < 10) ? WR : (r == 10) ? REF : NOP;
        if (c == ACT) a = 15'($urandom_range(0, 1));
        else a = {4'd0, 1'($urandom_range(0, 1)), 4'd0, 6'(($urandom_range(0, 7) + 60) % NCOL)};
        ddrcke = ($urandom_range(0, 29) != 0);
        step(c, a, 3'd0, 16'($urandom), ($urandom_range(0, 19) == 0));
        checks++; if (m_dq_known && ddrdqin !== m_dq) begin
          errors++; $display("FAIL rnd_dq r%0d i%0d: got %h exp %h", round, i, ddrdqin, m_dq);
        end
        checks++; if (err !== m_err || errcode !== 3'(m_code)) begin
          errors++; $display("FAIL rnd_err r%0d i%0d: got %b/%0d exp %b/%0d", round, i, err, errcode, m_err, m_code);
        end
        checks++; if (ready !== m_ready || mr !== {m_mr[3], m_mr[2], m_mr[1], m_mr[0]}) begin
          errors++; $display("FAIL rnd_ready_mr r%0d i%0d: got %b/%h exp %b", round, i, ready, mr, m_ready);
        end
      end
    end
  endtask

  initial begin
    m_edge = 0;
    for (int i = 0; i < (1 << (ROWW + COLW)); i++) begin
      m_mem[i] = '0; m_known[i] = 1'b0;
    end
    test_reset();
    test_init();
    test_write_read();
    test_wrap();
    test_violations();
    test_overlap();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
